// File: rtl/sym_err_monitor.sv
// sym_err_monitor
//   Symbol error-rate monitor for a K=3, rate-1/2 Viterbi decoder. Decoded
//   bits are re-encoded (G0=111, G1=101) and compared against the delayed
//   received symbol. Errors are counted over fixed windows of WIN symbols,
//   and a sticky alarm is raised when a window reaches THRESH errors.
//
//   Optional feature: define SYM_ERR_MON_TOTAL_EN to build the cumulative
//   saturating 24-bit error counter. Without it, total_errs is tied to 0.
//
// Ports
//   clk          clock, rising edge
//   reset        synchronous active-high reset
//   in_valid     dec_bit/dly_sym pair valid this cycle
//   dec_bit      decoded bit from traceback
//   dly_sym      delayed received symbol, [1]=G0 bit, [0]=G1 bit
//   clear_stats  clears counters, window result and alarm (not encoder)
//   win_errs     error count of the last completed window
//   win_done     one-cycle pulse when win_errs updates
//   alarm        sticky threshold alarm
//   total_errs   cumulative saturating error count
module sym_err_monitor #(
  parameter int unsigned WIN    = 256,
  parameter int unsigned THRESH = 32,
  parameter int unsigned ERR_W  = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic             dec_bit,
  input  logic [1:0]       dly_sym,
  input  logic             clear_stats,
  output logic [ERR_W-1:0] win_errs,
  output logic             win_done,
  output logic             alarm,
  output logic [23:0]      total_errs
);

  localparam int unsigned CNT_W = (WIN > 2) ? $clog2(WIN) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIN - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    ALARM = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [1:0]       enc_q, enc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [ERR_W-1:0] acc_q, acc_d;
  logic [ERR_W-1:0] win_errs_q, win_errs_d;
  logic             win_done_q, win_done_d;
  logic             alarm_q, alarm_d;

  logic [1:0]       code;
  logic [1:0]       sym_err;
  logic [1:0]       e;
  logic             accept;
  logic             close;
  logic [ERR_W-1:0] win_sum;

  // Re-encode the decoded bit and count mismatching symbol bits.
  always_comb begin
    code    = {dec_bit ^ enc_q[1] ^ enc_q[0], dec_bit ^ enc_q[0]};
    sym_err = code ^ dly_sym;
    e       = {1'b0, sym_err[1]} + {1'b0, sym_err[0]};
    // A symbol arriving with clear_stats advances the encoder but is not counted.
    accept  = in_valid && !clear_stats;
    close   = accept && (cnt_q == CNT_LAST);
    win_sum = acc_q + ERR_W'(e);
  end

  // Next-state logic for encoder, window counters, FSM and outputs.
  always_comb begin
    enc_d      = enc_q;
    cnt_d      = cnt_q;
    acc_d      = acc_q;
    win_errs_d = win_errs_q;
    win_done_d = 1'b0;
    state_d    = state_q;

    if (in_valid) begin
      enc_d = {dec_bit, enc_q[1]};
    end

    if (clear_stats) begin
      cnt_d      = '0;
      acc_d      = '0;
      win_errs_d = '0;
    end else if (accept) begin
      if (close) begin
        cnt_d      = '0;
        acc_d      = '0;
        win_errs_d = win_sum;
        win_done_d = 1'b1;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
        acc_d = win_sum;
      end
    end

    if (clear_stats) begin
      state_d = (state_q == IDLE) ? IDLE : ACCUM;
    end else if (close && (32'(win_sum) >= 32'(THRESH))) begin
      state_d = ALARM;
    end else if ((state_q == IDLE) && in_valid) begin
      state_d = ACCUM;
    end

    // Alarm tracks the next state so it rises with the triggering win_done.
    alarm_d = (state_d == ALARM);
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      enc_q      <= '0;
      cnt_q      <= '0;
      acc_q      <= '0;
      win_errs_q <= '0;
      win_done_q <= 1'b0;
      alarm_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      enc_q      <= enc_d;
      cnt_q      <= cnt_d;
      acc_q      <= acc_d;
      win_errs_q <= win_errs_d;
      win_done_q <= win_done_d;
      alarm_q    <= alarm_d;
    end
  end

  assign win_errs = win_errs_q;
  assign win_done = win_done_q;
  assign alarm    = alarm_q;

`ifdef SYM_ERR_MON_TOTAL_EN
  localparam int unsigned TOT_W = 24;

  logic [TOT_W-1:0] total_q, total_d;
  logic [TOT_W:0]   total_sum;

  // Cumulative error count, clamped at all-ones.
  always_comb begin
    total_sum = {1'b0, total_q} + (TOT_W + 1)'(e);
    total_d   = total_q;
    if (clear_stats) begin
      total_d = '0;
    end else if (accept) begin
      total_d = total_sum[TOT_W] ? {TOT_W{1'b1}} : total_sum[TOT_W-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      total_q <= '0;
    end else begin
      total_q <= total_d;
    end
  end

  assign total_errs = total_q;
`else
  assign total_errs = 24'd0;
`endif

endmodule

// File: tb/tb_sym_err_monitor.sv
// Bench for sym_err_monitor (WIN=4, THRESH=3): directed vector table,
// hand-written clear/reset/saturation sequences, then random traffic
// compared every cycle against a window-list reference model.
module tb_sym_err_monitor;

  localparam int unsigned WIN    = 4;
  localparam int unsigned THRESH = 3;
  localparam int unsigned ERR_W  = 16;
  localparam longint      TMAX   = 64'd16777215;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             in_valid = 1'b0;
  logic             dec_bit = 1'b0;
  logic [1:0]       dly_sym = 2'b00;
  logic             clear_stats = 1'b0;
  logic [ERR_W-1:0] win_errs;
  logic             win_done;
  logic             alarm;
  logic [23:0]      total_errs;

  sym_err_monitor #(.WIN(WIN), .THRESH(THRESH), .ERR_W(ERR_W)) dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .dec_bit     (dec_bit),
    .dly_sym     (dly_sym),
    .clear_stats (clear_stats),
    .win_errs    (win_errs),
    .win_done    (win_done),
    .alarm       (alarm),
    .total_errs  (total_errs)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic             rst;
    logic             iv;
    logic             db;
    logic [1:0]       ds;
    logic             clr;
    logic             e_done;
    logic [ERR_W-1:0] e_errs;
    logic             e_alarm;
  } vec_t;

  vec_t vt[$];

  int total_n = 0;
  int bad_n   = 0;

  // Reference model: history of accepted encoder bits and the error list of the open window.
  logic   bits_q[$];
  int     win_q[$];
  logic   m_done  = 1'b0;
  longint m_errs  = 0;
  logic   m_alarm = 1'b0;
  longint m_total = 0;

  function automatic vec_t mk(input logic rst, input logic iv, input logic db,
                              input logic [1:0] ds, input logic d,
                              input int errs, input logic al);
    vec_t v;
    v.rst = rst; v.iv = iv; v.db = db; v.ds = ds; v.clr = 1'b0;
    v.e_done = d; v.e_errs = ERR_W'(errs); v.e_alarm = al;
    return v;
  endfunction

  // Expected symbol for bit d: G0 taps d,d-1,d-2; G1 taps d,d-2.
  function automatic logic [1:0] ref_code(input logic d);
    logic p1, p2;
    int n;
    n  = bits_q.size();
    p1 = (n >= 1) ? bits_q[n-1] : 1'b0;
    p2 = (n >= 2) ? bits_q[n-2] : 1'b0;
    return {d ^ p1 ^ p2, d ^ p2};
  endfunction

  task automatic check(input string name, input longint act, input longint exp);
    total_n++;
    if (act != exp) begin
      bad_n++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  task automatic model_step(input logic rst, input logic iv, input logic db,
                            input logic [1:0] ds, input logic clr);
    int e;
    int sum;
    m_done = 1'b0;
    if (rst) begin
      bits_q.delete();
      win_q.delete();
      m_errs = 0; m_alarm = 1'b0; m_total = 0;
      return;
    end
    e = $countones(ref_code(db) ^ ds);
    if (iv) begin
      bits_q.push_back(db);
      if (bits_q.size() > 4) void'(bits_q.pop_front());
    end
    if (clr) begin
      win_q.delete();
      m_errs = 0; m_alarm = 1'b0; m_total = 0;
    end else if (iv) begin
      win_q.push_back(e);
`ifdef SYM_ERR_MON_TOTAL_EN
      m_total = (m_total + e > TMAX) ? TMAX : m_total + e;
`endif
      if (win_q.size() == WIN) begin
        sum = 0;
        foreach (win_q[k]) sum += win_q[k];
        win_q.delete();
        m_errs = sum;
        m_done = 1'b1;
        if (sum >= THRESH) m_alarm = 1'b1;
      end
    end
  endtask

  // One clock: drive, advance, update the model, compare all outputs.
  task automatic step(input logic rst, input logic iv, input logic db,
                      input logic [1:0] ds, input logic clr);
    reset = rst; in_valid = iv; dec_bit = db; dly_sym = ds; clear_stats = clr;
    @(posedge clk);
    #1;
    model_step(rst, iv, db, ds, clr);
    check("win_done", longint'(win_done), longint'(m_done));
    check("win_errs", longint'(win_errs), m_errs);
    check("alarm", longint'(alarm), longint'(m_alarm));
    check("total_errs", longint'(total_errs), m_total);
  endtask

  initial begin
    logic       d;
    logic [1:0] cs;

    // Directed windows: clean, two errors, all inverted then clean.
    vt.push_back(mk(1, 0, 0, 2'b00, 0, 0, 0));
    vt.push_back(mk(0, 1, 1, 2'b11, 0, 0, 0));
    vt.push_back(mk(0, 1, 0, 2'b10, 0, 0, 0));
    vt.push_back(mk(0, 1, 1, 2'b00, 0, 0, 0));
    vt.push_back(mk(0, 1, 1, 2'b01, 1, 0, 0));
    vt.push_back(mk(1, 0, 0, 2'b00, 0, 0, 0));
    vt.push_back(mk(0, 1, 1, 2'b00, 0, 0, 0));
    vt.push_back(mk(0, 1, 0, 2'b10, 0, 0, 0));
    vt.push_back(mk(0, 1, 1, 2'b00, 0, 0, 0));
    vt.push_back(mk(0, 1, 1, 2'b01, 1, 2, 0));
    vt.push_back(mk(0, 0, 0, 2'b00, 0, 2, 0));
    vt.push_back(mk(1, 0, 0, 2'b00, 0, 0, 0));
    vt.push_back(mk(0, 1, 1, 2'b00, 0, 0, 0));
    vt.push_back(mk(0, 1, 0, 2'b01, 0, 0, 0));
    vt.push_back(mk(0, 1, 1, 2'b11, 0, 0, 0));
    vt.push_back(mk(0, 1, 1, 2'b10, 1, 8, 1));
    vt.push_back(mk(0, 1, 0, 2'b01, 0, 8, 1));
    vt.push_back(mk(0, 1, 0, 2'b11, 0, 8, 1));
    vt.push_back(mk(0, 1, 0, 2'b00, 0, 8, 1));
    vt.push_back(mk(0, 1, 0, 2'b00, 1, 0, 1));

    for (int i = 0; i < vt.size(); i++) begin
      step(vt[i].rst, vt[i].iv, vt[i].db, vt[i].ds, vt[i].clr);
      check("tbl_done", longint'(win_done), longint'(vt[i].e_done));
      check("tbl_errs", longint'(win_errs), longint'(vt[i].e_errs));
      check("tbl_alarm", longint'(alarm), longint'(vt[i].e_alarm));
    end

    // Alarmed window: three bad symbols, then clear with a valid symbol on the close cycle.
    for (int i = 0; i < 3; i++) begin
      d = 1'($urandom_range(0, 1));
      step(0, 1, d, ~ref_code(d), 0);
    end
    step(0, 1, 1'b1, 2'b00, 1);
    check("clr_done", longint'(win_done), 0);
    check("clr_alarm", longint'(alarm), 0);
    check("clr_errs", longint'(win_errs), 0);
    check("clr_total", longint'(total_errs), 0);
    // Correct symbols only match if the encoder state survived the clear.
    for (int i = 0; i < 4; i++) begin
      d = 1'($urandom_range(0, 1));
      step(0, 1, d, ref_code(d), 0);
    end
    check("post_clr_done", longint'(win_done), 1);
    check("post_clr_errs", longint'(win_errs), 0);
    check("post_clr_alarm", longint'(alarm), 0);
    step(0, 0, 0, 2'b00, 0);

    // Reset partway through a window discards it.
    step(0, 1, 1'b1, 2'b10, 0);
    step(0, 1, 1'b0, 2'b01, 0);
    step(1, 1, 1'b1, 2'b11, 0);
    check("rst_done", longint'(win_done), 0);
    for (int i = 0; i < 3; i++) begin
      d = 1'($urandom_range(0, 1));
      step(0, 1, d, ~ref_code(d), 0);
    end
    check("rst_part_done", longint'(win_done), 0);
    d = 1'b1;
    step(0, 1, d, ref_code(d), 0);
    check("rst_win_done", longint'(win_done), 1);
    check("rst_win_errs", longint'(win_errs), 6);

`ifdef SYM_ERR_MON_TOTAL_EN
    // Preload near full scale and push two double-error symbols.
    force dut.total_q = 24'hFFFFFE;
    #1;
    release dut.total_q;
    m_total = 64'd16777214;
    for (int i = 0; i < 2; i++) begin
      d = 1'($urandom_range(0, 1));
      step(0, 1, d, ~ref_code(d), 0);
      check("sat_total", longint'(total_errs), TMAX);
    end
`else
    check("total_off", longint'(total_errs), 0);
`endif

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      int r;
      logic rst, clr, iv;
      r   = int'($urandom_range(0, 999));
      rst = (r < 5);
      clr = (r >= 5) && (r < 30);
      iv  = ($urandom_range(0, 9) < 7);
      d   = 1'($urandom_range(0, 1));
      cs  = ($urandom_range(0, 2) != 0) ? ref_code(d) : 2'($urandom_range(0, 3));
      step(rst, iv, d, cs, clr);
    end

    $display("test done: total=%0d bad=%0d", total_n, bad_n);
    $finish;
  end

endmodule

// File: doc/sym_err_monitor.md
SYM_ERR_MONITOR -- requirements
Module: sym_err_monitor

Interface
REQ-001 Parameter WIN, default 256: symbols per measurement window, at least 2.
REQ-002 Parameter THRESH, default 32: per-window error count at or above which the alarm asserts.
REQ-003 Parameter ERR_W, default 16: width of win_errs; must hold 2*WIN.
REQ-004 clk  input  1  single clock; all state changes on its rising edge.
REQ-005 reset  input  1  reset, synchronous and active-high.
REQ-006 in_valid  input  1  dec_bit/dly_sym pair valid this cycle.
REQ-007 dec_bit  input  1  decoded bit from traceback, aligned with dly_sym.
REQ-008 dly_sym  input  2  received symbol after 32-cycle delay line; [1]=G0 bit, [0]=G1 bit.
REQ-009 clear_stats  input  1  clears counters and alarm.
REQ-010 win_errs  output  ERR_W  error count of last completed window.
REQ-011 win_done  output  1  one-cycle pulse when win_errs updates.
REQ-012 alarm  output  1  sticky threshold alarm.
REQ-013 total_errs  output  24  cumulative saturating error count.

Function
REQ-014 Re-encoder: K=3 rate-1/2, G0=111, G1=101, 2-bit state s, s[1]=previous bit; c0=dec_bit^s[1]^s[0], c1=dec_bit^s[0]; s <= {dec_bit,s[1]} only on in_valid.
REQ-015 Per accepted symbol: e = popcount({c0,c1} ^ dly_sym), range 0..2.
REQ-016 FSM states IDLE, ACCUM, ALARM; reset -> IDLE; IDLE -> ACCUM on first in_valid; ACCUM -> ALARM on window close with count >= THRESH; ALARM -> ACCUM only on clear_stats.
REQ-017 Symbol counter 0..WIN-1 increments per accepted symbol and wraps to 0; accumulator adds e.
REQ-018 Window close on the accepted symbol with counter = WIN-1; next cycle win_errs = accumulator + e, win_done = 1 for exactly one cycle; latency 1 cycle.
REQ-019 At window close, the accumulator is reloaded with 0; the next accepted symbol starts the new window with no gap.
REQ-020 alarm = 1 exactly when state is ALARM, asserting in the same cycle as the win_done that triggered it; later windows below THRESH do not clear it.
REQ-021 Windows keep closing while in ALARM; win_errs/win_done behave as in ACCUM.
REQ-022 total_errs adds e per accepted symbol and saturates at 2^24-1 with no wrap.
REQ-023 in_valid low: no counter, accumulator, or encoder-state change.
REQ-024 clear_stats: next cycle symbol counter, accumulator, win_errs, and total_errs = 0, alarm = 0, state ACCUM (IDLE if in IDLE); encoder state not cleared.
REQ-025 clear_stats with in_valid in the same cycle: clear wins, symbol excluded from statistics, encoder state still advances.
REQ-026 clear_stats in the window-close cycle: no win_done pulse.

Reset
REQ-027 Reset overrides all inputs, including clear_stats.
REQ-028 Next cycle after reset: encoder state 00, counters 0, win_errs 0, win_done 0, alarm 0, total_errs 0, state IDLE.
REQ-029 Reset mid-window discards the partial window and generates no win_done.

Configuration
REQ-030 Macro SYM_ERR_MON_TOTAL_EN: when defined, the total_errs counter of REQ-022 is built.
REQ-031 When SYM_ERR_MON_TOTAL_EN is undefined, total_errs is constant 0, no counter registers exist, and all other behaviour is unchanged.

Verification
REQ-032 Reset, then dec_bit 1,0,1,1 with dly_sym 11,10,00,01 -> e=0 each; total_errs=0.
REQ-033 WIN=4, THRESH=3, same bits with dly_sym 00,10,00,01 -> win_done one cycle after 4th symbol, win_errs=2, alarm=0.
REQ-034 WIN=4, THRESH=3, dly_sym inverted on all 4 symbols -> win_errs=8, alarm=1 and stays 1 through a following clean window, win_errs=0.
REQ-035 clear_stats with in_valid during an alarmed window -> alarm=0, total_errs=0, counter=0, next re-encoded symbol correct (encoder state kept).
REQ-036 reset at symbol 2 of window with WIN=4 -> no win_done; a new window starts from 0 after reset.
REQ-037 total_errs preloaded near max (force 2^24-2), two symbols each e=2 -> total_errs=2^24-1 held; macro undefined -> total_errs=0 throughout.
